// File: rtl/sram_array_pkg.sv
// Shared types for the banked SRAM array: BIST state encoding, March C- element
// table and the bank-index width helper.
package sram_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_M0,
    ST_M1,
    ST_M2,
    ST_M3,
    ST_M4,
    ST_M5,
    ST_FLUSH
  } bist_state_e;

  typedef struct packed {
    logic down;
    logic rd_pat;
    logic wr_pat;
    logic has_rd;
    logic has_wr;
  } march_elem_t;

  // Element table for March C-; read always precedes write within an element.
  function automatic march_elem_t elem_of(input bist_state_e s);
    march_elem_t e;
    e = '0;
    case (s)
      ST_M0:   e = march_elem_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      ST_M1:   e = march_elem_t'{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      ST_M2:   e = march_elem_t'{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      ST_M3:   e = march_elem_t'{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      ST_M4:   e = march_elem_t'{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      ST_M5:   e = march_elem_t'{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic int bank_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_lane.sv
// One 8-bit byte-lane macro: single port, synchronous read, active-low select.
module sram_lane #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              csn,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        q
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (!csn) begin
      if (!wen) mem[addr] <= wdata;
      else      q <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_bank_array.sv
// Banked byte-lane SRAM with valid/ready access port, registered read return,
// DFT bypass register and an integrated March C- BIST across all lanes.
module sram_bank_array
  import sram_array_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int LANES     = 4,
  parameter int ADDR_W    = 13,
  localparam int BANK_W   = bank_w(NUM_BANKS)
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [BANK_W+ADDR_W-1:0]  req_addr,
  input  logic [LANES-1:0]          req_be,
  input  logic [8*LANES-1:0]        req_wdata,
  input  logic                      dft_en,
  output logic                      rd_valid,
  output logic [8*LANES-1:0]        rd_data,
  input  logic                      bist_start,
  output logic                      bist_busy,
  output logic                      bist_done,
  output logic [NUM_BANKS*LANES-1:0] bist_fail
);

  localparam int NL = NUM_BANKS * LANES;

  bist_state_e       state, nxt;
  march_elem_t       el;
  logic [ADDR_W-1:0] addr_cnt;
  logic              phase, cmp_valid, cmp_pat;
  logic              bist_act, bist_rd, bist_wr, two_op, last_addr, elem_end;
  logic              accept;
  logic [BANK_W-1:0] req_bank, rd_bank;
  logic              rd_pend, rd_oor, rd_byp;
  logic [8*LANES-1:0] byp_q, mux_data;
  logic [7:0]        lane_q [NL];

  assign req_ready = !bist_busy;
  assign accept    = req_valid && req_ready;
  assign req_bank  = req_addr[ADDR_W +: BANK_W];

  always_comb begin
    el        = elem_of(state);
    nxt       = bist_state_e'(state + 3'd1);
    bist_act  = (state != ST_IDLE) && (state != ST_FLUSH);
    two_op    = el.has_rd && el.has_wr;
    bist_rd   = bist_act && el.has_rd && (!el.has_wr || !phase);
    bist_wr   = bist_act && el.has_wr && (!el.has_rd || phase);
    last_addr = el.down ? (addr_cnt == '0) : (addr_cnt == '1);
    elem_end  = last_addr && (!two_op || phase);
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic user_en;
      assign user_en = accept && !dft_en && (req_bank == BANK_W'(b)) && (!req_write || req_be[i]);
      sram_lane #(.ADDR_W(ADDR_W)) u_lane (
        .clk   (hclk),
        .csn   (!(bist_rd || bist_wr || user_en)),
        .wen   (bist_act ? !bist_wr : !req_write),
        .addr  (bist_act ? addr_cnt : req_addr[ADDR_W-1:0]),
        .wdata (bist_act ? {8{el.wr_pat}} : req_wdata[8*i +: 8]),
        .q     (lane_q[b*LANES+i])
      );
    end
  end

  always_comb begin
    mux_data = '0;
    if (int'(rd_bank) < NUM_BANKS) begin
      for (int i = 0; i < LANES; i++) mux_data[8*i +: 8] = lane_q[int'(rd_bank)*LANES + i];
    end
  end

  // Lane macros return data one edge after accept; this stage aligns rd_valid.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rd_pend  <= 1'b0;
      rd_bank  <= '0;
      rd_oor   <= 1'b0;
      rd_byp   <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      byp_q    <= '0;
    end else begin
      rd_pend <= accept && !req_write;
      if (accept && !req_write) begin
        rd_bank <= req_bank;
        rd_oor  <= int'(req_bank) >= NUM_BANKS;
        rd_byp  <= dft_en;
      end
      if (accept && req_write && dft_en) byp_q <= req_wdata;
      rd_valid <= rd_pend;
      if (rd_pend) rd_data <= rd_byp ? byp_q : (rd_oor ? '0 : mux_data);
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= ST_IDLE;
      addr_cnt  <= '0;
      phase     <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_pat   <= 1'b0;
      bist_busy <= 1'b0;
      bist_done <= 1'b0;
      bist_fail <= '0;
    end else begin
      cmp_valid <= bist_rd;
      cmp_pat   <= el.rd_pat;
      if (cmp_valid) begin
        for (int k = 0; k < NL; k++)
          if (lane_q[k] != {8{cmp_pat}}) bist_fail[k] <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          // A same-cycle access wins; a held bist_start is taken next cycle.
          if (bist_start && !accept) begin
            state     <= ST_M0;
            addr_cnt  <= '0;
            phase     <= 1'b0;
            bist_busy <= 1'b1;
            bist_done <= 1'b0;
            bist_fail <= '0;
          end
        end
        ST_FLUSH: begin
          state     <= ST_IDLE;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
        end
        default: begin
          if (two_op) phase <= !phase;
          if (elem_end) begin
            state    <= nxt;
            addr_cnt <= elem_of(nxt).down ? '1 : '0;
          end else if (!two_op || phase) begin
            addr_cnt <= el.down ? addr_cnt - 1'b1 : addr_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule
